// File: rtl/rs_issue_select_pkg.sv
// Shared types and default sizes for the reservation-station issue slice.
package rs_issue_select_pkg;

  localparam int RS_NUM_ENTRIES = 8;
  localparam int RS_TAG_W       = 6;
  localparam int RS_PAYLOAD_W   = 32;

  // One reservation-station slot. Widths follow the package defaults; the
  // top-level TAG_W / PAYLOAD_W parameters are expected to match them.
  typedef struct packed {
    logic                    valid;
    logic                    rdy1;
    logic                    rdy2;
    logic [RS_TAG_W-1:0]     src1_tag;
    logic [RS_TAG_W-1:0]     src2_tag;
    logic [RS_TAG_W-1:0]     dest_tag;
    logic [RS_PAYLOAD_W-1:0] payload;
  } rs_entry_t;

endpackage

// File: rtl/rs_issue_select_age.sv
// Age matrix for the RS: older_q[i][j]=1 means slot i was dispatched before
// slot j. Produces a one-hot grant for the oldest candidate. Freed slots need
// no update because the caller masks them out of the candidate vector.
module rs_age_matrix #(
  parameter int NUM_RS_ENTRIES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_RS_ENTRIES-1:0] valid,
  input  logic [NUM_RS_ENTRIES-1:0] alloc_0,
  input  logic [NUM_RS_ENTRIES-1:0] alloc_1,
  input  logic [NUM_RS_ENTRIES-1:0] cand,
  output logic [NUM_RS_ENTRIES-1:0] grant
);

  logic [NUM_RS_ENTRIES-1:0][NUM_RS_ENTRIES-1:0] older_q;
  logic [NUM_RS_ENTRIES-1:0][NUM_RS_ENTRIES-1:0] older_d;

  // Next matrix: a newly allocated slot is younger than everything live;
  // port 1 is additionally younger than a same-cycle port-0 allocation.
  always_comb begin
    // NOTE: every bit gets a default before the conditional updates so no
    // latch is inferred for paths that leave a bit unassigned.
    older_d = older_q;
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      for (int j = 0; j < NUM_RS_ENTRIES; j++) begin
        if (alloc_0[i] || alloc_1[i]) older_d[i][j] = 1'b0;
        if (alloc_0[j]) older_d[i][j] = (i != j) && valid[i];
        if (alloc_1[j]) older_d[i][j] = (i != j) && (valid[i] || alloc_0[i]);
      end
    end
  end

  // Matrix register; flush discards all ordering along with the entries.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst)        older_q <= '0;
    else if (flush) older_q <= '0;
    else            older_q <= older_d;
  end

  // Oldest-first select: a candidate wins when no other candidate is older.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      grant[i] = cand[i];
      for (int j = 0; j < NUM_RS_ENTRIES; j++) begin
        if (cand[j] && older_q[j][i]) grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_issue_select.sv
// Reservation-station issue side: dual dispatch write, two-bus wakeup,
// oldest-ready select into a registered issue stage, slot return to the
// allocator. Optional macro RS_ISSUE_PERF_EN adds stall_cnt / ready_cnt.
module rs_issue_select
  import rs_issue_select_pkg::*;
#(
  parameter int  NUM_RS_ENTRIES = RS_NUM_ENTRIES,
  parameter int  TAG_W          = RS_TAG_W,
  parameter int  PAYLOAD_W      = RS_PAYLOAD_W,
  localparam int IDX_W          = $clog2(NUM_RS_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_valid_0,
  input  logic [IDX_W-1:0]     disp_idx_0,
  input  logic [TAG_W-1:0]     disp_src1_tag_0,
  input  logic [TAG_W-1:0]     disp_src2_tag_0,
  input  logic                 disp_src1_rdy_0,
  input  logic                 disp_src2_rdy_0,
  input  logic [TAG_W-1:0]     disp_dest_tag_0,
  input  logic [PAYLOAD_W-1:0] disp_payload_0,
  input  logic                 disp_valid_1,
  input  logic [IDX_W-1:0]     disp_idx_1,
  input  logic [TAG_W-1:0]     disp_src1_tag_1,
  input  logic [TAG_W-1:0]     disp_src2_tag_1,
  input  logic                 disp_src1_rdy_1,
  input  logic                 disp_src2_rdy_1,
  input  logic [TAG_W-1:0]     disp_dest_tag_1,
  input  logic [PAYLOAD_W-1:0] disp_payload_1,
  input  logic                 wk_valid_0,
  input  logic [TAG_W-1:0]     wk_tag_0,
  input  logic                 wk_valid_1,
  input  logic [TAG_W-1:0]     wk_tag_1,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [TAG_W-1:0]     issue_src1_tag,
  output logic [TAG_W-1:0]     issue_src2_tag,
  output logic [TAG_W-1:0]     issue_dest_tag,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic [IDX_W-1:0]     issue_idx,
  output logic                 free_valid,
  output logic [IDX_W:0]       free_idx
`ifdef RS_ISSUE_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [IDX_W:0]       ready_cnt
`endif
);

  rs_entry_t entries_q [NUM_RS_ENTRIES];
  rs_entry_t entries_d [NUM_RS_ENTRIES];
  rs_entry_t new_entry_0;
  rs_entry_t new_entry_1;
  rs_entry_t win_entry;

  logic [NUM_RS_ENTRIES-1:0] valid_vec;
  logic [NUM_RS_ENTRIES-1:0] cand_vec;
  logic [NUM_RS_ENTRIES-1:0] grant_vec;
  logic [NUM_RS_ENTRIES-1:0] alloc_0;
  logic [NUM_RS_ENTRIES-1:0] alloc_1;
  logic [IDX_W-1:0]          win_idx;
  logic                      advance;
  logic                      do_issue;

  // Flatten per-slot status into vectors for the select logic.
  always_comb begin
    valid_vec = '0;
    cand_vec  = '0;
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      cand_vec[i]  = entries_q[i].valid && entries_q[i].rdy1 && entries_q[i].rdy2;
    end
  end

  // Decode dispatch slots and build the new entries, folding in a
  // same-cycle wakeup so a just-broadcast source is not missed.
  always_comb begin
    alloc_0 = '0;
    alloc_1 = '0;
    if (disp_valid_0) alloc_0[disp_idx_0] = 1'b1;
    if (disp_valid_1) alloc_1[disp_idx_1] = 1'b1;

    new_entry_0.valid    = 1'b1;
    new_entry_0.rdy1     = disp_src1_rdy_0 || (wk_valid_0 && wk_tag_0 == disp_src1_tag_0)
                                           || (wk_valid_1 && wk_tag_1 == disp_src1_tag_0);
    new_entry_0.rdy2     = disp_src2_rdy_0 || (wk_valid_0 && wk_tag_0 == disp_src2_tag_0)
                                           || (wk_valid_1 && wk_tag_1 == disp_src2_tag_0);
    new_entry_0.src1_tag = disp_src1_tag_0;
    new_entry_0.src2_tag = disp_src2_tag_0;
    new_entry_0.dest_tag = disp_dest_tag_0;
    new_entry_0.payload  = disp_payload_0;

    new_entry_1.valid    = 1'b1;
    new_entry_1.rdy1     = disp_src1_rdy_1 || (wk_valid_0 && wk_tag_0 == disp_src1_tag_1)
                                           || (wk_valid_1 && wk_tag_1 == disp_src1_tag_1);
    new_entry_1.rdy2     = disp_src2_rdy_1 || (wk_valid_0 && wk_tag_0 == disp_src2_tag_1)
                                           || (wk_valid_1 && wk_tag_1 == disp_src2_tag_1);
    new_entry_1.src1_tag = disp_src1_tag_1;
    new_entry_1.src2_tag = disp_src2_tag_1;
    new_entry_1.dest_tag = disp_dest_tag_1;
    new_entry_1.payload  = disp_payload_1;
  end

  rs_age_matrix #(
    .NUM_RS_ENTRIES(NUM_RS_ENTRIES)
  ) u_age (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .valid   (valid_vec),
    .alloc_0 (alloc_0),
    .alloc_1 (alloc_1),
    .cand    (cand_vec),
    .grant   (grant_vec)
  );

  assign advance  = !issue_valid || issue_ready;
  assign do_issue = advance && (|grant_vec);

  // One-hot grant to index and winner fields.
  always_comb begin
    win_idx   = '0;
    win_entry = '0;
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      if (grant_vec[i]) begin
        win_idx   = IDX_W'(i);
        win_entry = entries_q[i];
      end
    end
  end

  // Per-slot next state: wakeup, release on issue, then dispatch overwrite.
  always_comb begin
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        if ((wk_valid_0 && wk_tag_0 == entries_q[i].src1_tag) ||
            (wk_valid_1 && wk_tag_1 == entries_q[i].src1_tag)) entries_d[i].rdy1 = 1'b1;
        if ((wk_valid_0 && wk_tag_0 == entries_q[i].src2_tag) ||
            (wk_valid_1 && wk_tag_1 == entries_q[i].src2_tag)) entries_d[i].rdy2 = 1'b1;
      end
      if (do_issue && grant_vec[i]) entries_d[i].valid = 1'b0;
      if (alloc_0[i]) entries_d[i] = new_entry_0;
      if (alloc_1[i]) entries_d[i] = new_entry_1;
    end
  end

  // Entry storage register; flush overrides dispatch, wakeup and issue.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the whole entry array is reset, not just the valid bits: it is a
    // small flop array and clearing it keeps tags/payload deterministic.
    if (rst || flush) begin
      for (int i = 0; i < NUM_RS_ENTRIES; i++) entries_q[i] <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

  // Issue stage register and slot-return pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      issue_valid    <= 1'b0;
      issue_src1_tag <= '0;
      issue_src2_tag <= '0;
      issue_dest_tag <= '0;
      issue_payload  <= '0;
      issue_idx      <= '0;
      free_valid     <= 1'b0;
      free_idx       <= '0;
    end else begin
      free_valid <= do_issue;
      if (do_issue) free_idx <= {1'b0, win_idx};
      if (advance) begin
        issue_valid <= |grant_vec;
        if (|grant_vec) begin
          issue_src1_tag <= win_entry.src1_tag;
          issue_src2_tag <= win_entry.src2_tag;
          issue_dest_tag <= win_entry.dest_tag;
          issue_payload  <= win_entry.payload;
          issue_idx      <= win_idx;
        end
      end
    end
  end

`ifdef RS_ISSUE_PERF_EN
  // Saturating count of cycles the FU held off a valid issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      stall_cnt <= '0;
    end else if (issue_valid && !issue_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Number of slots currently ready to issue.
  always_comb begin
    ready_cnt = '0;
    if (!flush) begin
      for (int i = 0; i < NUM_RS_ENTRIES; i++) ready_cnt = ready_cnt + (IDX_W+1)'(cand_vec[i]);
    end
  end
`else
  // Performance counters not built.
`endif

  // Allocator contract: dispatch targets only free slots, never the same one twice.
  a_disp0_free: assert property (@(posedge clk) disable iff (rst)
    (disp_valid_0 && !flush) |-> !valid_vec[disp_idx_0]);
  a_disp1_free: assert property (@(posedge clk) disable iff (rst)
    (disp_valid_1 && !flush) |-> !valid_vec[disp_idx_1]);
  a_disp_distinct: assert property (@(posedge clk) disable iff (rst)
    (disp_valid_0 && disp_valid_1 && !flush) |-> (disp_idx_0 != disp_idx_1));

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select; build with +define+RS_ISSUE_PERF_EN to
// also cover the counters.
module tb_rs_issue_select;

  localparam int N         = 8;
  localparam int TAG_W     = 6;
  localparam int PAYLOAD_W = 32;
  localparam int IDX_W     = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush;
  logic                 disp_valid_0, disp_valid_1;
  logic [IDX_W-1:0]     disp_idx_0, disp_idx_1;
  logic [TAG_W-1:0]     disp_src1_tag_0, disp_src2_tag_0, disp_dest_tag_0;
  logic [TAG_W-1:0]     disp_src1_tag_1, disp_src2_tag_1, disp_dest_tag_1;
  logic                 disp_src1_rdy_0, disp_src2_rdy_0, disp_src1_rdy_1, disp_src2_rdy_1;
  logic [PAYLOAD_W-1:0] disp_payload_0, disp_payload_1;
  logic                 wk_valid_0, wk_valid_1;
  logic [TAG_W-1:0]     wk_tag_0, wk_tag_1;
  logic                 issue_valid, issue_ready;
  logic [TAG_W-1:0]     issue_src1_tag, issue_src2_tag, issue_dest_tag;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic [IDX_W-1:0]     issue_idx;
  logic                 free_valid;
  logic [IDX_W:0]       free_idx;
`ifdef RS_ISSUE_PERF_EN
  logic [31:0]          stall_cnt;
  logic [IDX_W:0]       ready_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rs_issue_select dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid_0(disp_valid_0), .disp_idx_0(disp_idx_0),
    .disp_src1_tag_0(disp_src1_tag_0), .disp_src2_tag_0(disp_src2_tag_0),
    .disp_src1_rdy_0(disp_src1_rdy_0), .disp_src2_rdy_0(disp_src2_rdy_0),
    .disp_dest_tag_0(disp_dest_tag_0), .disp_payload_0(disp_payload_0),
    .disp_valid_1(disp_valid_1), .disp_idx_1(disp_idx_1),
    .disp_src1_tag_1(disp_src1_tag_1), .disp_src2_tag_1(disp_src2_tag_1),
    .disp_src1_rdy_1(disp_src1_rdy_1), .disp_src2_rdy_1(disp_src2_rdy_1),
    .disp_dest_tag_1(disp_dest_tag_1), .disp_payload_1(disp_payload_1),
    .wk_valid_0(wk_valid_0), .wk_tag_0(wk_tag_0),
    .wk_valid_1(wk_valid_1), .wk_tag_1(wk_tag_1),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_src1_tag(issue_src1_tag), .issue_src2_tag(issue_src2_tag),
    .issue_dest_tag(issue_dest_tag), .issue_payload(issue_payload),
    .issue_idx(issue_idx), .free_valid(free_valid), .free_idx(free_idx)
`ifdef RS_ISSUE_PERF_EN
    , .stall_cnt(stall_cnt), .ready_cnt(ready_cnt)
`endif
  );

  // Issue view as one word: {valid, idx, payload}.
  function automatic logic [35:0] iss(input logic v, input logic [IDX_W-1:0] idx,
                                      input logic [PAYLOAD_W-1:0] pl);
    return {v, idx, pl};
  endfunction

  task automatic clear_inputs();
    flush = 1'b0;
    disp_valid_0 = 1'b0; disp_idx_0 = '0; disp_src1_tag_0 = '0; disp_src2_tag_0 = '0;
    disp_src1_rdy_0 = 1'b0; disp_src2_rdy_0 = 1'b0; disp_dest_tag_0 = '0; disp_payload_0 = '0;
    disp_valid_1 = 1'b0; disp_idx_1 = '0; disp_src1_tag_1 = '0; disp_src2_tag_1 = '0;
    disp_src1_rdy_1 = 1'b0; disp_src2_rdy_1 = 1'b0; disp_dest_tag_1 = '0; disp_payload_1 = '0;
    wk_valid_0 = 1'b0; wk_tag_0 = '0; wk_valid_1 = 1'b0; wk_tag_1 = '0;
  endtask

  task automatic drive_disp0(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] s1t, input logic s1r,
                             input logic [TAG_W-1:0] s2t, input logic s2r, input logic [PAYLOAD_W-1:0] pl);
    disp_valid_0 = 1'b1; disp_idx_0 = idx; disp_src1_tag_0 = s1t; disp_src1_rdy_0 = s1r;
    disp_src2_tag_0 = s2t; disp_src2_rdy_0 = s2r; disp_payload_0 = pl; disp_dest_tag_0 = pl[TAG_W-1:0];
  endtask

  task automatic drive_disp1(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] s1t, input logic s1r,
                             input logic [TAG_W-1:0] s2t, input logic s2r, input logic [PAYLOAD_W-1:0] pl);
    disp_valid_1 = 1'b1; disp_idx_1 = idx; disp_src1_tag_1 = s1t; disp_src1_rdy_1 = s1r;
    disp_src2_tag_1 = s2t; disp_src2_rdy_1 = s2r; disp_payload_1 = pl; disp_dest_tag_1 = pl[TAG_W-1:0];
  endtask

  // Advance past one rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    issue_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] exp;
    clear_inputs();
    issue_ready = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp = iss(1'b0, 3'd0, 32'd0);
    checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
      $display("FAIL reset_issue: got %h want %h", iss(issue_valid, issue_idx, issue_payload), exp); end
    checks++; if ({free_valid, free_idx, issue_src1_tag, issue_src2_tag, issue_dest_tag} !== 23'd0) begin failures++;
      $display("FAIL reset_fields: got %h want 0", {free_valid, free_idx, issue_src1_tag, issue_src2_tag, issue_dest_tag}); end
`ifdef RS_ISSUE_PERF_EN
    checks++; if ({stall_cnt, ready_cnt} !== 36'd0) begin failures++;
      $display("FAIL reset_perf: got %h want 0", {stall_cnt, ready_cnt}); end
`endif
    // Asynchronous reset in the middle of a cycle.
    drive_disp0(3'd2, 6'd1, 1'b1, 6'd2, 1'b1, 32'h5A);
    tick(); clear_inputs();
    tick();
    exp = iss(1'b1, 3'd2, 32'h5A);
    checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
      $display("FAIL async_pre: got %h want %h", iss(issue_valid, issue_idx, issue_payload), exp); end
    issue_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp = iss(1'b0, 3'd0, 32'd0);
    checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
      $display("FAIL async_reset: got %h want %h", iss(issue_valid, issue_idx, issue_payload), exp); end
    #1 rst = 1'b0;
    issue_ready = 1'b1;
  endtask

  task automatic test_single_op();
    logic [35:0] exp;
    do_reset();
    drive_disp0(3'd3, 6'd7, 1'b1, 6'd9, 1'b1, 32'hA5);
    tick(); clear_inputs();
    checks++; if (issue_valid !== 1'b0) begin failures++;
      $display("FAIL single_edge1: issue_valid got %b want 0", issue_valid); end
    tick();
    exp = iss(1'b1, 3'd3, 32'hA5);
    checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
      $display("FAIL single_issue: got %h want %h", iss(issue_valid, issue_idx, issue_payload), exp); end
    checks++; if ({issue_src1_tag, issue_src2_tag, issue_dest_tag} !== {6'd7, 6'd9, 6'h25}) begin failures++;
      $display("FAIL single_tags: got %h want %h", {issue_src1_tag, issue_src2_tag, issue_dest_tag}, {6'd7, 6'd9, 6'h25}); end
    checks++; if ({free_valid, free_idx} !== {1'b1, 4'd3}) begin failures++;
      $display("FAIL single_free: got %h want %h", {free_valid, free_idx}, {1'b1, 4'd3}); end
    tick();
    checks++; if ({issue_valid, free_valid} !== 2'b00) begin failures++;
      $display("FAIL single_drain: got %b want 00", {issue_valid, free_valid}); end
  endtask

  task automatic test_wakeup();
    logic [35:0] exp;
    do_reset();
    drive_disp0(3'd1, 6'd12, 1'b0, 6'd3, 1'b1, 32'hB1);
    tick(); clear_inputs();
    wk_valid_1 = 1'b1; wk_tag_1 = 6'd13;
    tick(); clear_inputs();
    checks++; if (issue_valid !== 1'b0) begin failures++;
      $display("FAIL wake_wrongtag: issue_valid got %b want 0", issue_valid); end
    wk_valid_1 = 1'b1; wk_tag_1 = 6'd12;
    tick(); clear_inputs();
    checks++; if (issue_valid !== 1'b0) begin failures++;
      $display("FAIL wake_early: issue_valid got %b want 0", issue_valid); end
    tick();
    exp = iss(1'b1, 3'd1, 32'hB1);
    checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
      $display("FAIL wake_issue: got %h want %h", iss(issue_valid, issue_idx, issue_payload), exp); end
    // Wakeup in the same cycle as dispatch is captured.
    drive_disp0(3'd6, 6'd4, 1'b1, 6'd20, 1'b0, 32'hC6);
    wk_valid_0 = 1'b1; wk_tag_0 = 6'd20;
    tick(); clear_inputs();
    checks++; if (issue_valid !== 1'b0) begin failures++;
      $display("FAIL wake_same_e1: issue_valid got %b want 0", issue_valid); end
    tick();
    exp = iss(1'b1, 3'd6, 32'hC6);
    checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
      $display("FAIL wake_same_issue: got %h want %h", iss(issue_valid, issue_idx, issue_payload), exp); end
  endtask

  task automatic test_age_order();
    logic [35:0] exp;
    do_reset();
    drive_disp0(3'd5, 6'd1, 1'b1, 6'd2, 1'b1, 32'h55);
    drive_disp1(3'd2, 6'd1, 1'b1, 6'd2, 1'b1, 32'h22);
    tick(); clear_inputs();
    tick();
    exp = iss(1'b1, 3'd5, 32'h55);
    checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
      $display("FAIL age_first: got %h want %h", iss(issue_valid, issue_idx, issue_payload), exp); end
    tick();
    exp = iss(1'b1, 3'd2, 32'h22);
    checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
      $display("FAIL age_second: got %h want %h", iss(issue_valid, issue_idx, issue_payload), exp); end
    checks++; if ({free_valid, free_idx} !== {1'b1, 4'd2}) begin failures++;
      $display("FAIL age_free: got %h want %h", {free_valid, free_idx}, {1'b1, 4'd2}); end
    tick();
    checks++; if (issue_valid !== 1'b0) begin failures++;
      $display("FAIL age_empty: issue_valid got %b want 0", issue_valid); end
  endtask

  task automatic test_back_pressure();
    logic [35:0] exp;
    do_reset();
    drive_disp0(3'd0, 6'd1, 1'b1, 6'd2, 1'b1, 32'h10);
    drive_disp1(3'd7, 6'd1, 1'b1, 6'd2, 1'b1, 32'h11);
    tick(); clear_inputs();
    drive_disp0(3'd4, 6'd1, 1'b1, 6'd2, 1'b1, 32'h12);
    tick(); clear_inputs();
    issue_ready = 1'b0;
    exp = iss(1'b1, 3'd0, 32'h10);
    checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
      $display("FAIL bp_load: got %h want %h", iss(issue_valid, issue_idx, issue_payload), exp); end
    for (int s = 0; s < 4; s++) begin
      tick();
      checks++; if ({iss(issue_valid, issue_idx, issue_payload), free_valid} !== {exp, 1'b0}) begin failures++;
        $display("FAIL bp_hold%0d: got %h want %h", s, {iss(issue_valid, issue_idx, issue_payload), free_valid}, {exp, 1'b0}); end
    end
`ifdef RS_ISSUE_PERF_EN
    checks++; if ({stall_cnt, ready_cnt} !== {32'd4, 4'd2}) begin failures++;
      $display("FAIL bp_perf: got %h want %h", {stall_cnt, ready_cnt}, {32'd4, 4'd2}); end
`endif
    issue_ready = 1'b1;
    tick();
    exp = iss(1'b1, 3'd7, 32'h11);
    checks++; if ({iss(issue_valid, issue_idx, issue_payload), free_valid, free_idx} !== {exp, 1'b1, 4'd7}) begin failures++;
      $display("FAIL bp_resume1: got %h want %h", {iss(issue_valid, issue_idx, issue_payload), free_valid, free_idx}, {exp, 1'b1, 4'd7}); end
    tick();
    exp = iss(1'b1, 3'd4, 32'h12);
    checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
      $display("FAIL bp_resume2: got %h want %h", iss(issue_valid, issue_idx, issue_payload), exp); end
    tick();
    checks++; if (issue_valid !== 1'b0) begin failures++;
      $display("FAIL bp_empty: issue_valid got %b want 0", issue_valid); end
`ifdef RS_ISSUE_PERF_EN
    checks++; if (stall_cnt !== 32'd4) begin failures++;
      $display("FAIL bp_stall_keep: got %0d want 4", stall_cnt); end
`endif
  endtask

  task automatic test_full_reuse();
    int order [8] = '{6, 2, 7, 0, 3, 5, 1, 4};
    logic [35:0] exp;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive_disp0(IDX_W'(order[2*c]),   6'd40, 1'b0, 6'd1, 1'b1, 32'h30 + 32'(2*c));
      drive_disp1(IDX_W'(order[2*c+1]), 6'd40, 1'b0, 6'd1, 1'b1, 32'h31 + 32'(2*c));
      tick(); clear_inputs();
    end
    checks++; if (issue_valid !== 1'b0) begin failures++;
      $display("FAIL full_notready: issue_valid got %b want 0", issue_valid); end
    wk_valid_0 = 1'b1; wk_tag_0 = 6'd40;
    tick(); clear_inputs();
    checks++; if (issue_valid !== 1'b0) begin failures++;
      $display("FAIL full_wake_comb: issue_valid got %b want 0", issue_valid); end
`ifdef RS_ISSUE_PERF_EN
    checks++; if (ready_cnt !== 4'd8) begin failures++;
      $display("FAIL full_ready_cnt: got %0d want 8", ready_cnt); end
`endif
    tick();
    exp = iss(1'b1, 3'd6, 32'h30);
    checks++; if ({iss(issue_valid, issue_idx, issue_payload), free_valid, free_idx} !== {exp, 1'b1, 4'd6}) begin failures++;
      $display("FAIL full_first: got %h want %h", {iss(issue_valid, issue_idx, issue_payload), free_valid, free_idx}, {exp, 1'b1, 4'd6}); end
    drive_disp0(3'd6, 6'd1, 1'b1, 6'd2, 1'b1, 32'h3F);
    for (int k = 1; k < 8; k++) begin
      tick(); clear_inputs();
      exp = iss(1'b1, IDX_W'(order[k]), 32'h30 + 32'(k));
      checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
        $display("FAIL full_order%0d: got %h want %h", k, iss(issue_valid, issue_idx, issue_payload), exp); end
    end
    tick();
    exp = iss(1'b1, 3'd6, 32'h3F);
    checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
      $display("FAIL full_reused: got %h want %h", iss(issue_valid, issue_idx, issue_payload), exp); end
    tick();
    checks++; if (issue_valid !== 1'b0) begin failures++;
      $display("FAIL full_empty: issue_valid got %b want 0", issue_valid); end
  endtask

  task automatic test_flush();
    logic [35:0] exp;
    do_reset();
    issue_ready = 1'b0;
    drive_disp0(3'd1, 6'd1, 1'b1, 6'd2, 1'b1, 32'h41);
    drive_disp1(3'd2, 6'd1, 1'b1, 6'd2, 1'b1, 32'h42);
    tick(); clear_inputs();
    drive_disp0(3'd3, 6'd1, 1'b1, 6'd2, 1'b1, 32'h43);
    drive_disp1(3'd4, 6'd1, 1'b1, 6'd2, 1'b1, 32'h44);
    tick(); clear_inputs();
    drive_disp0(3'd5, 6'd1, 1'b1, 6'd2, 1'b1, 32'h45);
    drive_disp1(3'd6, 6'd1, 1'b1, 6'd2, 1'b1, 32'h46);
    tick(); clear_inputs();
    exp = iss(1'b1, 3'd1, 32'h41);
    checks++; if (iss(issue_valid, issue_idx, issue_payload) !== exp) begin failures++;
      $display("FAIL flush_pre: got %h want %h", iss(issue_valid, issue_idx, issue_payload), exp); end
    flush = 1'b1; issue_ready = 1'b1;
    drive_disp0(3'd0, 6'd1, 1'b1, 6'd2, 1'b1, 32'h99);
    tick(); clear_inputs();
    checks++; if ({issue_valid, issue_idx, issue_payload, issue_dest_tag, free_valid, free_idx} !== 47'd0) begin failures++;
      $display("FAIL flush_clear: got %h want 0", {issue_valid, issue_idx, issue_payload, issue_dest_tag, free_valid, free_idx}); end
`ifdef RS_ISSUE_PERF_EN
    checks++; if ({stall_cnt, ready_cnt} !== 36'd0) begin failures++;
      $display("FAIL flush_perf: got %h want 0", {stall_cnt, ready_cnt}); end
`endif
    tick();
    checks++; if ({issue_valid, free_valid} !== 2'b00) begin failures++;
      $display("FAIL flush_dropped: got %b want 00", {issue_valid, free_valid}); end
    drive_disp0(3'd0, 6'd1, 1'b1, 6'd2, 1'b1, 32'h77);
    tick(); clear_inputs();
    tick();
    exp = iss(1'b1, 3'd0, 32'h77);
    checks++; if ({iss(issue_valid, issue_idx, issue_payload), free_valid, free_idx} !== {exp, 1'b1, 4'd0}) begin failures++;
      $display("FAIL flush_fresh: got %h want %h", {iss(issue_valid, issue_idx, issue_payload), free_valid, free_idx}, {exp, 1'b1, 4'd0}); end
    tick();
    checks++; if (issue_valid !== 1'b0) begin failures++;
      $display("FAIL flush_empty: issue_valid got %b want 0", issue_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op();
    test_wakeup();
    test_age_order();
    test_back_pressure();
    test_full_reuse();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_issue_select.md
Name: rs_issue_select

Overview:
- Issue side of a reservation station; pairs with the RS free-slot allocator.
- Dispatch writes up to two entries per cycle into slot indices already granted by the allocator.
- Result-bus broadcasts wake up source operands; the oldest fully-ready entry goes into a registered issue stage toward the functional unit.
- The vacated slot index is handed back to the allocator on its issue_free_valid/issue_free return port.

Parameters:
- NUM_RS_ENTRIES, 8, number of RS slots; power of two, ≥ 2.
- TAG_W, 6, physical register tag width.
- PAYLOAD_W, 32, opaque micro-op payload width (opcode, imm, ROB id).
- IDX_W, $clog2(NUM_RS_ENTRIES), slot index width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  pipeline flush; synchronous clear.
- disp_valid_0  in  1  dispatch write, port 0 (older).
- disp_idx_0  in  IDX_W  slot from allocator free_0.
- disp_src1_tag_0, disp_src2_tag_0  in  TAG_W each  source tags.
- disp_src1_rdy_0, disp_src2_rdy_0  in  1 each  source already available.
- disp_dest_tag_0  in  TAG_W  destination tag.
- disp_payload_0  in  PAYLOAD_W  payload.
- disp_*_1  in  same as _0  dispatch port 1 (younger); idx from free_1.
- wk_valid_0, wk_valid_1  in  1 each  wakeup broadcasts.
- wk_tag_0, wk_tag_1  in  TAG_W each  broadcast tags.
- issue_valid  out  1  issue register holds a micro-op.
- issue_ready  in  1  FU accepts.
- issue_src1_tag, issue_src2_tag, issue_dest_tag  out  TAG_W each.
- issue_payload  out  PAYLOAD_W.
- issue_idx  out  IDX_W  slot the op came from.
- free_valid  out  1  pulse: slot returned to allocator.
- free_idx  out  IDX_W+1  returned slot, MSB always 0.

Behaviour:
- Per-entry state: valid, rdy1, rdy2, tags, payload, plus an NxN age matrix; older[i][j]=1 means i is older than j.
- Dispatch (port p, slot k):
  - valid[k]<=1.
  - rdyN <= disp_rdyN | (wk_valid_x & wk_tag_x==disp_srcN_tag), so a same-cycle wakeup counts.
  - older[j][k]<=valid[j] for every other j; older[k][j]<=0.
  - Dual dispatch: port 0 is older than port 1.
  - Dispatch to a slot already valid is illegal (assertion).
- Wakeup: every valid entry whose srcN tag matches either broadcast sets rdyN<=1 at the next edge. A woken entry is selectable one cycle later, never combinationally.
- Select: candidate i = valid[i] & rdy1[i] & rdy2[i]. Winner = the candidate with no older candidate. At most one winner, one-hot.
- Issue register advances when !issue_valid | issue_ready.
  - Advance with a winner: load winner fields, issue_valid<=1, valid[winner]<=0, free_valid<=1 and free_idx<={1'b0,winner} at the same edge.
  - Advance without a winner: issue_valid<=0.
  - Stall: hold all issue outputs stable.
- Issue latency: a dispatch with both sources ready reaches issue_valid at the second edge after dispatch (entry written at edge 1, selected at edge 2).
- free_valid is a single-cycle pulse per freed slot.
- Dispatch may write a slot freed in the previous cycle. Dispatch and select never target the same slot in one cycle.
- Full: all slots valid → allocator stops dispatch; the block has no back-pressure output.
- Empty: issue_valid falls after the last op is accepted.
- Reset and flush: all valid/rdy bits and the age matrix clear; issue_valid=0, free_valid=0, free_idx=0, issue_* fields=0.
  - flush beats same-cycle dispatch, wakeup and issue.
  - free_valid stays 0 on flush, because the allocator rebuilds its own list.
  - rst mid-operation acts immediately (asynchronous).

Optional Feature:
- Macro RS_ISSUE_PERF_EN.
- Defined: adds output port stall_cnt (32 bits) counting cycles with issue_valid & !issue_ready, and output ready_cnt (IDX_W+1 bits), the combinational number of ready candidates. Both are 0 on reset and flush; stall_cnt saturates at all-ones.
- Undefined: neither port nor its logic exists.

Decomposition:
- parameter_pkg: rs_entry_t struct (valid, rdy1, rdy2, src1_tag, src2_tag, dest_tag, payload) and the default TAG_W.
- Sub-module rs_age_matrix(NUM_RS_ENTRIES): holds the matrix, takes two allocate one-hot vectors and the candidate vector, outputs a one-hot oldest-grant. Deallocation needs no update because cleared valid masks the entry.

Test Plan:
- Single op: reset; dispatch port0 idx 3, both rdy=1, payload 0xA5 → edge+2 issue_valid=1, issue_idx=3, issue_payload=0xA5, free_valid pulse with free_idx=3.
- Wakeup: dispatch idx 1 with src1 tag 12 not ready; wk tag 12 two cycles later → issue_valid exactly two edges after the wakeup edge, not earlier.
- Age order: dual dispatch idx 5 (port0) and idx 2 (port1), both ready → issue idx 5 first, then 2, despite 2 being the lower index.
- Back-pressure: issue_ready=0 for 4 cycles with 3 ready entries → outputs stable, no free_valid, stall_cnt=4 when RS_ISSUE_PERF_EN is defined; then one issue per cycle in age order.
- Full and reuse: fill all 8 slots, drain one, redispatch into the freed idx → new op is the youngest, issued after all remaining ready ops.
- Flush: flush with 5 valid entries and issue_valid=1 → next cycle issue_valid=0, no free_valid, a fresh dispatch to idx 0 issues normally.
